el2_exu_div_sender: RTL and testbench
=====================================

# el2_exu_div_sender

Divider-side NoC injector for the EL2 execution unit. Captures each 32-bit divide result when the divider pulses `finish`, buffers up to two results, and serializes each one LSB-first as a packet of fixed-width flits under a valid/ready handshake. It sits directly upstream of `el2_exu_div_receiver` across the NoC, and must produce the flit framing that the receiver's serial deserializer expects.

## Interface
Parameters:
- `PACKET_BITS`, default 32: result width per packet.
- `FLIT_BITS`, default 8: NoC flit payload width; must be ≥1 and ≤`PACKET_BITS`.

Ports:
- `clk_noc`  in  1  NoC clock, the only clock.
- `rst_l`  in  1  reset, asynchronous, active-low.
- `finish`  in  1  one-cycle pulse from the divider: `out` is valid this cycle.
- `out`  in  `PACKET_BITS`  divide result.
- `noc_sr_flush`  in  1  discard results not yet started on the NoC.
- `up_valid`  out  1  flit valid.
- `up_data`  out  `FLIT_BITS`  flit payload.
- `up_last`  out  1  final flit of the packet.
- `up_ready`  in  1  NoC accepts the flit.
- `busy`  out  1  pending slot occupied; the divider must not issue.
- `overflow`  out  1  sticky: a result was dropped.

## Operation
- `NFLITS = ceil(PACKET_BITS/FLIT_BITS)`; padding of `NFLITS*FLIT_BITS-PACKET_BITS` zero bits occupies the MSBs of the last flit.
- Storage: one active shift register plus flit counter (0..NFLITS-1), and one pending register with a valid bit.
- FSM states:
  - IDLE: no active packet.
  - SEND: the active packet is being offered.
  - IDLE→SEND when a result is loaded into the active register.
  - SEND→IDLE after the last flit is accepted and nothing is pending.
  - SEND→SEND with a reload when the last flit is accepted while the pending slot is valid.
- Capture (`finish`=1):
  - In IDLE, or in the same cycle the last flit is accepted with pending empty: the result loads into the active register.
  - Otherwise, if pending is empty: the result goes to pending.
  - Otherwise: the result is dropped and `overflow` is set. `overflow` is cleared only by reset.
- A flit is transferred on an edge where `up_valid & up_ready`; the shift register then shifts right by `FLIT_BITS`.
- While `up_valid & !up_ready`, `up_data` and `up_last` are held stable.
- `up_last` = `up_valid` and counter == NFLITS-1.
- `noc_sr_flush`:
  - Always clears pending.
  - Drops the active packet if no flit of it has been accepted yet (counter==0).
  - A packet with ≥1 flit accepted always completes, so NoC framing is never broken.
  - A `finish` in the same cycle as flush is discarded; flush has priority.
- `busy` = pending valid.

## Timing
- Reset values: `up_valid`=0, `up_data`=0, `up_last`=0, `busy`=0, `overflow`=0, FSM=IDLE, pending invalid.
- Latency: `finish` at edge t (block in IDLE) → `up_valid`=1 with flit 0 in cycle t+1.
- With `up_ready` held high, a packet occupies exactly NFLITS cycles.
- Back-to-back packets from pending have no bubble cycle.
- `busy` asserts the cycle after a capture into pending, and deasserts the cycle after pending moves into the active register.
- Reset asserted mid-packet aborts immediately to the reset values.

## Configuration
- `EL2_DIV_SENDER_CNT_EN`:
  - Defined: adds output `pkt_cnt[15:0]`. It resets to 0, increments on each last-flit acceptance, and saturates at 0xFFFF.
  - Undefined: the port and counter do not exist. All other behaviour is identical.

## Structure
- The FSM state enum `el2_div_snd_state_e` (IDLE, SEND) and a helper constant function computing NFLITS belong in `noc_types`, shared with the receiver side.
- One sub-module is natural: `noc_serial_sender`, a generic serializer (active register, counter, handshake, flush rule). `el2_exu_div_sender` adds the pending slot, `busy`/`overflow`, and the counter option around it.

## Test plan
- FLIT_BITS=8, `finish` with 0xDEADBEEF, `up_ready`=1 → flits EF,BE,AD,DE in cycles t+1..t+4; `up_last` only on DE.
- Same packet, `up_ready` low for 3 cycles at flit 1 → BE held stable for 4 cycles; the sequence is unchanged.
- Two `finish` pulses 1 cycle apart (0x11223344, 0x55667788), `up_ready`=1 → 8 contiguous flits 44,33,22,11,88,77,66,55; `busy` high between the captures and the reload.
- Third `finish` while active and pending are both full → third result never appears; `overflow`=1 until reset.
- Flush in the cycle before the first flit is accepted → nothing sent. Flush after 2 flits accepted → the full 4-flit packet completes and pending is discarded.
- FLIT_BITS=12, 0xFFFFFFFF → flits FFF, FFF, 0FF; `up_last` on the 3rd; 4 padding zeros.

Source files
------------

// File: rtl/noc_types.sv
// Shared NoC types for the EL2 divider sender/receiver pair.
package noc_types;

  // Serializer FSM states, shared with the receiver side.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } el2_div_snd_state_e;

  // Number of flits needed to carry a packet (ceiling division).
  function automatic int noc_nflits(input int packet_bits, input int flit_bits);
    return (packet_bits + flit_bits - 1) / flit_bits;
  endfunction

endpackage

// File: rtl/noc_serial_sender.sv
// Generic LSB-first packet serializer: active shift register, flit counter,
// valid/ready handshake and the flush-before-first-flit rule.
//
// Handshake: a flit moves on a rising edge where up_valid & up_ready are both
// high. up_valid never depends on up_ready, and while up_valid is high and
// up_ready is low, up_data/up_last stay unchanged until the transfer happens.
module noc_serial_sender
  import noc_types::*;
#(
  parameter int PACKET_BITS = 32,
  parameter int FLIT_BITS   = 8
) (
  input  logic                   clk_noc,
  input  logic                   rst_l,
  input  logic                   load_valid,
  input  logic [PACKET_BITS-1:0] load_data,
  input  logic                   flush,
  output logic                   up_valid,
  output logic [FLIT_BITS-1:0]   up_data,
  output logic                   up_last,
  input  logic                   up_ready,
  output el2_div_snd_state_e     state_o,
  output logic                   last_accept_o
);

  localparam int NFLITS = noc_nflits(PACKET_BITS, FLIT_BITS);
  localparam int SR_W   = NFLITS * FLIT_BITS;
  localparam int CW     = (NFLITS > 1) ? $clog2(NFLITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NFLITS - 1);

  el2_div_snd_state_e state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic xfer;
  logic at_last;

  assign xfer    = (state_q == SEND) && up_ready;
  assign at_last = (cnt_q == LAST_CNT);

  assign up_valid      = (state_q == SEND);
  assign up_data       = up_valid ? sr_q[FLIT_BITS-1:0] : '0;
  assign up_last       = up_valid && at_last;
  assign last_accept_o = xfer && at_last;
  assign state_o       = state_q;

  // Next state: a load wins, then a transfer, then a flush of an unstarted packet.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    if (load_valid) begin
      state_d = SEND;
      sr_d    = SR_W'(load_data);
      cnt_d   = '0;
    end else if (xfer) begin
      if (at_last) begin
        state_d = IDLE;
        sr_d    = '0;
        cnt_d   = '0;
      end else begin
        sr_d  = sr_q >> FLIT_BITS;
        cnt_d = cnt_q + CW'(1);
      end
    end else if (flush && (state_q == SEND) && (cnt_q == '0)) begin
      // No flit of this packet has left yet, so dropping it keeps framing intact.
      state_d = IDLE;
      sr_d    = '0;
    end
  end

  // State, shift register and flit counter registers.
  always_ff @(posedge clk_noc or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/el2_exu_div_sender.sv
// Divider-side NoC injector: captures divide results, holds one in a pending
// slot behind the active packet, and serializes them as flits.
// Optional EL2_DIV_SENDER_CNT_EN adds a saturating 16-bit packet counter output.
module el2_exu_div_sender
  import noc_types::*;
#(
  parameter int PACKET_BITS = 32,
  parameter int FLIT_BITS   = 8
) (
  input  logic                   clk_noc,
  input  logic                   rst_l,
  input  logic                   finish,
  input  logic [PACKET_BITS-1:0] out,
  input  logic                   noc_sr_flush,
  output logic                   up_valid,
  output logic [FLIT_BITS-1:0]   up_data,
  output logic                   up_last,
  input  logic                   up_ready,
  output logic                   busy,
  output logic                   overflow
`ifdef EL2_DIV_SENDER_CNT_EN
  ,
  output logic [15:0]            pkt_cnt
`endif
);

  el2_div_snd_state_e     snd_state;
  logic                   last_accept;
  logic                   load_valid;
  logic [PACKET_BITS-1:0] load_data;

  logic                   pend_v_q, pend_v_d;
  logic [PACKET_BITS-1:0] pend_q, pend_d;
  logic                   ovf_q, ovf_d;

  noc_serial_sender #(
    .PACKET_BITS (PACKET_BITS),
    .FLIT_BITS   (FLIT_BITS)
  ) u_ser (
    .clk_noc       (clk_noc),
    .rst_l         (rst_l),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .flush         (noc_sr_flush),
    .up_valid      (up_valid),
    .up_data       (up_data),
    .up_last       (up_last),
    .up_ready      (up_ready),
    .state_o       (snd_state),
    .last_accept_o (last_accept)
  );

  // Capture routing: reload from pending, load a new result, park it, or drop it.
  always_comb begin
    pend_v_d   = pend_v_q;
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    load_valid = 1'b0;
    load_data  = pend_q;
    if (noc_sr_flush) begin
      // Flush clears pending and swallows any same-cycle finish.
      pend_v_d = 1'b0;
    end else begin
      if (last_accept && pend_v_q) begin
        load_valid = 1'b1;
        load_data  = pend_q;
        pend_v_d   = 1'b0;
      end
      if (finish) begin
        if ((snd_state == IDLE) || (last_accept && !pend_v_q)) begin
          load_valid = 1'b1;
          load_data  = out;
        end else if (!pend_v_q) begin
          pend_v_d = 1'b1;
          pend_d   = out;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  // Pending slot and sticky overflow registers.
  always_ff @(posedge clk_noc or negedge rst_l) begin
    if (!rst_l) begin
      pend_v_q <= 1'b0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = pend_v_q;
  assign overflow = ovf_q;

`ifdef EL2_DIV_SENDER_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of completed packets.
  always_comb begin
    cnt_d = cnt_q;
    if (last_accept && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Packet counter register.
  always_ff @(posedge clk_noc or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_el2_exu_div_sender.sv
// Self-checking bench for el2_exu_div_sender (8-bit and 12-bit flit builds).
module tb_el2_exu_div_sender;

  // ---------------- clock / reset / DUT signals ----------------
  logic clk_noc = 1'b0;
  always #5 clk_noc = ~clk_noc;

  logic        rst_l;
  logic        finish;
  logic [31:0] out;
  logic        noc_sr_flush;
  logic        up_ready;
  logic        up_valid;
  logic [7:0]  up_data;
  logic        up_last;
  logic        busy;
  logic        overflow;

  logic        fin12;
  logic [31:0] out12;
  logic        ready12;
  logic        uv12;
  logic [11:0] ud12;
  logic        ul12;
  logic        busy12;
  logic        ovf12;

`ifdef EL2_DIV_SENDER_CNT_EN
  logic [15:0] pkt_cnt;
  logic [15:0] pkt_cnt12;
`endif

  el2_exu_div_sender #(.PACKET_BITS(32), .FLIT_BITS(8)) dut (
    .clk_noc      (clk_noc),
    .rst_l        (rst_l),
    .finish       (finish),
    .out          (out),
    .noc_sr_flush (noc_sr_flush),
    .up_valid     (up_valid),
    .up_data      (up_data),
    .up_last      (up_last),
    .up_ready     (up_ready),
    .busy         (busy),
    .overflow     (overflow)
`ifdef EL2_DIV_SENDER_CNT_EN
    ,
    .pkt_cnt      (pkt_cnt)
`endif
  );

  el2_exu_div_sender #(.PACKET_BITS(32), .FLIT_BITS(12)) dut12 (
    .clk_noc      (clk_noc),
    .rst_l        (rst_l),
    .finish       (fin12),
    .out          (out12),
    .noc_sr_flush (1'b0),
    .up_valid     (uv12),
    .up_data      (ud12),
    .up_last      (ul12),
    .up_ready     (ready12),
    .busy         (busy12),
    .overflow     (ovf12)
`ifdef EL2_DIV_SENDER_CNT_EN
    ,
    .pkt_cnt      (pkt_cnt12)
`endif
  );

  // ---------------- behavioural model (packet level) ----------------
  logic        m_act_v;
  logic [31:0] m_act;
  int          m_idx;      // flits of the active packet already accepted
  logic        m_pend_v;
  logic [31:0] m_pend;
  logic        m_ovf;
  int          m_cnt;

  int n_vec;
  int n_err;
  int busy_cycles;

  logic [8:0]  acc_q[$];    // accepted flits {last, data}
  logic [7:0]  obs_q[$];    // data of every valid cycle
  logic [12:0] acc12_q[$];
  logic [8:0]  exp_q[$];

  task automatic model_reset();
    m_act_v  = 1'b0;
    m_act    = '0;
    m_idx    = 0;
    m_pend_v = 1'b0;
    m_pend   = '0;
    m_ovf    = 1'b0;
    m_cnt    = 0;
  endtask

  function automatic logic [7:0] m_data();
    logic [31:0] sh;
    sh = m_act >> (8 * m_idx);
    return m_act_v ? sh[7:0] : 8'h00;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic was_v;
    logic pend_old;
    int   idx_old;
    logic xfer;
    logic done;
    was_v    = m_act_v;
    pend_old = m_pend_v;
    idx_old  = m_idx;
    xfer     = m_act_v && up_ready;
    done     = xfer && (m_idx == 3);
    if (xfer) begin
      m_idx = m_idx + 1;
      if (done) begin
        m_act_v = 1'b0;
        m_idx   = 0;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
    end
    if (noc_sr_flush) begin
      m_pend_v = 1'b0;
      if (was_v && idx_old == 0 && !xfer) m_act_v = 1'b0;
    end else begin
      if (done && pend_old) begin
        m_act_v  = 1'b1;
        m_act    = m_pend;
        m_idx    = 0;
        m_pend_v = 1'b0;
      end
      if (finish) begin
        if (!was_v || (done && !pend_old)) begin
          m_act_v = 1'b1;
          m_act   = out;
          m_idx   = 0;
        end else if (!pend_old) begin
          m_pend_v = 1'b1;
          m_pend   = out;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] sh;
      sh = w >> (8 * i);
      exp_q.push_back({(i == 3), sh[7:0]});
    end
  endtask

  task automatic cmp_acc(input string nm);
    chk({nm, "_count"}, 32'(acc_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      chk($sformatf("%s_flit%0d", nm, i), 32'(acc_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic clear_obs();
    acc_q.delete();
    obs_q.delete();
    exp_q.delete();
    acc12_q.delete();
    busy_cycles = 0;
  endtask

  // One cycle: compare on the falling edge, then advance the model at the rising edge.
  task automatic tick();
    @(negedge clk_noc);
    if (!rst_l) model_reset();
    chk("up_valid", 32'(up_valid), 32'(m_act_v));
    chk("up_data",  32'(up_data),  32'(m_data()));
    chk("up_last",  32'(up_last),  32'(m_act_v && m_idx == 3));
    chk("busy",     32'(busy),     32'(m_pend_v));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef EL2_DIV_SENDER_CNT_EN
    chk("pkt_cnt",  32'(pkt_cnt),  32'(m_cnt));
`endif
    if (up_valid && up_ready) acc_q.push_back({up_last, up_data});
    if (up_valid) obs_q.push_back(up_data);
    if (busy) busy_cycles = busy_cycles + 1;
    if (uv12 && ready12) acc12_q.push_back({ul12, ud12});
    @(posedge clk_noc);
    if (!rst_l) model_reset();
    else model_step();
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int be_cnt;
    n_vec = 0;
    n_err = 0;
    rst_l = 1'b0;
    finish = 1'b0;
    out = '0;
    noc_sr_flush = 1'b0;
    up_ready = 1'b0;
    fin12 = 1'b0;
    out12 = '0;
    ready12 = 1'b0;
    model_reset();
    clear_obs();

    // Reset values.
    #2;
    chk("rst_up_valid", 32'(up_valid), 32'd0);
    chk("rst_up_data",  32'(up_data),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    tick();
    tick();
    rst_l = 1'b1;
    tick();

    // DEADBEEF on 8-bit flits, FFFFFFFF on 12-bit flits, ready high.
    clear_obs();
    finish = 1'b1; out = 32'hDEADBEEF; up_ready = 1'b1;
    fin12 = 1'b1; out12 = 32'hFFFFFFFF; ready12 = 1'b1;
    tick();
    finish = 1'b0; fin12 = 1'b0;
    chk("lat_valid", 32'(up_valid), 32'd1);
    chk("lat_flit0", 32'(up_data), 32'hEF);
    repeat (6) tick();
    exp_q.push_back({1'b0, 8'hEF});
    exp_q.push_back({1'b0, 8'hBE});
    exp_q.push_back({1'b0, 8'hAD});
    exp_q.push_back({1'b1, 8'hDE});
    cmp_acc("deadbeef");
    chk("deadbeef_cycles", 32'(obs_q.size()), 32'd4);
    chk("f12_count", 32'(acc12_q.size()), 32'd3);
    if (acc12_q.size() == 3) begin
      chk("f12_flit0", 32'(acc12_q[0]), 32'h0FFF);
      chk("f12_flit1", 32'(acc12_q[1]), 32'h0FFF);
      chk("f12_flit2", 32'(acc12_q[2]), 32'h10FF);
    end

    // Stall at flit 1 for three cycles.
    clear_obs();
    finish = 1'b1; out = 32'hDEADBEEF; up_ready = 1'b1;
    tick();
    finish = 1'b0;
    tick();
    up_ready = 1'b0;
    repeat (3) tick();
    up_ready = 1'b1;
    repeat (5) tick();
    push_word(32'hDEADBEEF);
    cmp_acc("stall");
    be_cnt = 0;
    foreach (obs_q[i]) if (obs_q[i] == 8'hBE) be_cnt++;
    chk("stall_be_held", 32'(be_cnt), 32'd4);

    // Two results back to back: no bubble, busy across the wait.
    clear_obs();
    finish = 1'b1; out = 32'h11223344;
    tick();
    out = 32'h55667788;
    tick();
    finish = 1'b0;
    repeat (9) tick();
    push_word(32'h11223344);
    push_word(32'h55667788);
    cmp_acc("b2b");
    chk("b2b_valid_cycles", 32'(obs_q.size()), 32'd8);
    chk("b2b_busy_cycles", 32'(busy_cycles), 32'd3);

    // Third result with both slots full is dropped.
    clear_obs();
    finish = 1'b1; out = 32'hA1A2A3A4;
    tick();
    out = 32'hB1B2B3B4;
    tick();
    out = 32'hC1C2C3C4;
    tick();
    finish = 1'b0;
    repeat (10) tick();
    push_word(32'hA1A2A3A4);
    push_word(32'hB1B2B3B4);
    cmp_acc("ovf");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    tick();
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Flush before the first flit is accepted: nothing leaves.
    clear_obs();
    up_ready = 1'b0;
    finish = 1'b1; out = 32'h12345678;
    tick();
    finish = 1'b0; noc_sr_flush = 1'b1;
    tick();
    noc_sr_flush = 1'b0; up_ready = 1'b1;
    repeat (6) tick();
    cmp_acc("flush_early");

    // Flush after two flits: packet completes, pending discarded.
    clear_obs();
    finish = 1'b1; out = 32'hCAFEF00D;
    tick();
    out = 32'h0BADBEEF;
    tick();
    finish = 1'b0;
    tick();
    noc_sr_flush = 1'b1;
    tick();
    noc_sr_flush = 1'b0;
    repeat (6) tick();
    push_word(32'hCAFEF00D);
    cmp_acc("flush_late");
    chk("flush_late_busy", 32'(busy), 32'd0);

    // Reset in the middle of a packet aborts at once.
    finish = 1'b1; out = 32'h87654321;
    tick();
    finish = 1'b0;
    repeat (2) tick();
    rst_l = 1'b0;
    #1;
    chk("midrst_valid", 32'(up_valid), 32'd0);
    chk("midrst_data",  32'(up_data),  32'd0);
    tick();
    rst_l = 1'b1;
    tick();

    // Randomized traffic against the model.
    repeat (3000) begin
      rst_l        = ($urandom_range(0, 299) != 0);
      finish       = ($urandom_range(0, 2) == 0);
      out          = $urandom;
      noc_sr_flush = ($urandom_range(0, 19) == 0);
      up_ready     = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
